cv32e40x_fpga_sleep_ctrl: RTL and testbench

//  Drives en_i of the core clock gate (upstream stage of cv32e40x_clock_gate).
//  On a core sleep request (WFI) it drains outstanding instr/data bus traffic,

---
 rtl/cv32e40x_fpga_sleep_ctrl_pkg.sv | 29 ++
 rtl/cv32e40x_fpga_sat_counter.sv | 42 ++++
 rtl/cv32e40x_fpga_sleep_ctrl.sv | 127 ++++++++++++
 tb/tb_cv32e40x_fpga_sleep_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40x_fpga_sleep_ctrl_pkg.sv
// ============================================================================
// cv32e40x_fpga_pkg : shared types and bounds for the FPGA sleep controller
// Rev 1.0
// ============================================================================
`default_nettype none

package cv32e40x_fpga_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } sleep_state_e;

  localparam int unsigned DRAIN_TIMEOUT_MIN = 1;
  localparam int unsigned DRAIN_TIMEOUT_MAX = 65535;
  localparam int unsigned WAKE_DELAY_MAX    = 15;

  // Bits needed to hold the larger of the two limits; never less than one bit.
  function automatic int cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cv32e40x_fpga_sat_counter.sv
// ============================================================================
// cv32e40x_fpga_sat_counter : clearable, saturating up-counter with equality compare
// Rev 1.0
// ============================================================================
`default_nettype none

module cv32e40x_fpga_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] cmp_i,
  output logic             eq_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign eq_o = (cnt_q == cmp_i);

endmodule

`default_nettype wire

// File: rtl/cv32e40x_fpga_sleep_ctrl.sv
// ============================================================================
// cv32e40x_fpga_sleep_ctrl : WFI drain / clock-gate enable / wake settle control
// Rev 1.0
// ============================================================================
`default_nettype none

module cv32e40x_fpga_sleep_ctrl
  import cv32e40x_fpga_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = 255,
  parameter int unsigned WAKE_DELAY    = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sleep_req_i,
  input  logic if_busy_i,
  input  logic lsu_busy_i,
  input  logic irq_pending_i,
  input  logic debug_req_i,
  input  logic wake_i,
  output logic clk_en_o,
  output logic core_ready_o,
  output logic sleeping_o,
  output logic sleep_abort_o
);

  localparam int               CNT_W      = cnt_width(DRAIN_TIMEOUT, WAKE_DELAY);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_DELAY);

  if ((DRAIN_TIMEOUT < DRAIN_TIMEOUT_MIN) || (DRAIN_TIMEOUT > DRAIN_TIMEOUT_MAX)) begin : g_bad_drain_timeout
    $error("DRAIN_TIMEOUT out of range 1..65535");
  end
  if (WAKE_DELAY > WAKE_DELAY_MAX) begin : g_bad_wake_delay
    $error("WAKE_DELAY out of range 0..15");
  end

  sleep_state_e     state_q, state_d;
  logic             clk_en_q, clk_en_d;
  logic             core_ready_q, core_ready_d;
  logic             sleeping_q, sleeping_d;
  logic             sleep_abort_q, sleep_abort_d;
  logic             cnt_clr, cnt_en, cnt_eq;
  logic [CNT_W-1:0] cnt_cmp;
  logic             wake, busy;

  assign wake = irq_pending_i | debug_req_i | wake_i;
  assign busy = if_busy_i | lsu_busy_i;

  always_comb begin
    state_d       = state_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    cnt_cmp       = DRAIN_LAST;
    sleep_abort_d = 1'b0;
    unique case (state_q)
      RUN: begin
        cnt_clr = 1'b1;
        if (sleep_req_i && !wake) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_en = 1'b1;
        // A wake (or withdrawn request) beats a bus that just went idle.
        if (wake || !sleep_req_i) begin
          state_d = RUN;
        end else if (!busy) begin
          state_d = SLEEP;
        end else if (cnt_eq) begin
          state_d       = RUN;
          sleep_abort_d = 1'b1;
        end
      end
      SLEEP: begin
        cnt_clr = 1'b1;
        if (wake) state_d = WAKE;
      end
      WAKE: begin
        cnt_en  = 1'b1;
        cnt_cmp = WAKE_LAST;
        if (cnt_eq) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs follow the registered state, so each lags its transition by one cycle.
  always_comb begin
    clk_en_d     = (state_q != SLEEP);
    core_ready_d = (state_q == RUN);
    sleeping_d   = (state_q == SLEEP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      clk_en_q      <= 1'b1;
      core_ready_q  <= 1'b1;
      sleeping_q    <= 1'b0;
      sleep_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_en_q      <= clk_en_d;
      core_ready_q  <= core_ready_d;
      sleeping_q    <= sleeping_d;
      sleep_abort_q <= sleep_abort_d;
    end
  end

  cv32e40x_fpga_sat_counter #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cmp_i (cnt_cmp),
    .eq_o  (cnt_eq)
  );

  assign clk_en_o      = clk_en_q;
  assign core_ready_o  = core_ready_q;
  assign sleeping_o    = sleeping_q;
  assign sleep_abort_o = sleep_abort_q;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40x_fpga_sleep_ctrl.sv
// ============================================================================
// tb_cv32e40x_fpga_sleep_ctrl : scoreboard bench, expected output edges from scenario timing
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cv32e40x_fpga_sleep_ctrl;

  localparam int DT = 8;
  localparam int WD = 2;

  logic clk = 1'b0;
  logic rst_i, sleep_req_i, if_busy_i, lsu_busy_i, irq_pending_i, debug_req_i, wake_i;
  logic clk_en_o, core_ready_o, sleeping_o, sleep_abort_o;

  typedef struct {
    int         cyc;
    logic [3:0] v;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  logic [3:0] prev_v = 4'b1100;

  cv32e40x_fpga_sleep_ctrl #(
    .DRAIN_TIMEOUT (DT),
    .WAKE_DELAY    (WD)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .sleep_req_i   (sleep_req_i),
    .if_busy_i     (if_busy_i),
    .lsu_busy_i    (lsu_busy_i),
    .irq_pending_i (irq_pending_i),
    .debug_req_i   (debug_req_i),
    .wake_i        (wake_i),
    .clk_en_o      (clk_en_o),
    .core_ready_o  (core_ready_o),
    .sleeping_o    (sleeping_o),
    .sleep_abort_o (sleep_abort_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] outs();
    return {clk_en_o, core_ready_o, sleeping_o, sleep_abort_o};
  endfunction

  // Pops one expectation every time the output vector changes.
  task automatic monitor();
    logic [3:0] cur;
    exp_t       ent;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = outs();
        if (sleeping_o) begin
          n_cmp++;
          if (if_busy_i || lsu_busy_i) begin
            n_bad++;
            $display("FAIL busy_while_sleeping cyc=%0d if=%b lsu=%b required both 0", cyc, if_busy_i, lsu_busy_i);
          end
        end
        if (cur !== prev_v) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change cyc=%0d got=%b prev=%b (no change expected)", cyc, cur, prev_v);
          end else begin
            ent = exp_q.pop_front();
            if ((ent.cyc != cyc) || (ent.v !== cur)) begin
              n_bad++;
              $display("FAIL out_change got cyc=%0d vec=%b required cyc=%0d vec=%b", cyc, cur, ent.cyc, ent.v);
            end
          end
          prev_v = cur;
        end
      end
    end
  endtask

  // b: busy cycles; e: edge at which the exit event is first seen;
  // typ: 0 drop sleep_req, 1 irq, 2 debug, 3 wake_i; bsrc: 0 if, 1 lsu, 2 both.
  task automatic run_scn(input int b, input int e_in, input int typ_in, input bit drop_sleep, input int bsrc);
    int         e, typ, s, a, r1, len, base;
    bit         sleeps, aborts;
    logic [3:0] pv, v;
    exp_t       ent;
    e      = e_in;
    typ    = typ_in;
    a      = DT + 1;
    s      = (b + 1 > 2) ? b + 1 : 2;
    sleeps = (b <= DT) && (e > s);
    aborts = (b > DT) && (e > a);
    if (sleeps && typ == 0) typ = 1;
    if (aborts) begin
      typ = 0;
      e   = a + 1;
    end
    r1   = sleeps ? e + WD + 2 : (aborts ? a + 1 : e + 1);
    len  = r1 + 3;
    base = cyc;
    pv   = 4'b1100;
    for (int k = 1; k <= len; k++) begin
      v[3] = !(sleeps && k >= s + 1 && k <= e);
      v[2] = !(k >= 2 && k < r1);
      v[1] = !v[3];
      v[0] = aborts && (k == a);
      if (v !== pv) begin
        ent.cyc = base + k;
        ent.v   = v;
        exp_q.push_back(ent);
      end
      pv = v;
    end
    for (int k = 1; k <= len; k++) begin
      sleep_req_i   = !((typ == 0 && k >= e) || (drop_sleep && sleeps && k >= s + 1));
      if_busy_i     = (k <= b) && (bsrc != 1);
      lsu_busy_i    = (k <= b) && (bsrc != 0);
      irq_pending_i = (typ == 1) && (k >= e);
      debug_req_i   = (typ == 2) && (k >= e);
      wake_i        = (typ == 3) && (k >= e);
      @(posedge clk); #1;
    end
    {sleep_req_i, if_busy_i, lsu_busy_i, irq_pending_i, debug_req_i, wake_i} = '0;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_vec(input string name, input logic [3:0] req);
    n_cmp++;
    if (outs() !== req) begin
      n_bad++;
      $display("FAIL %s got=%b required=%b", name, outs(), req);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_i = 1'b1;
    {sleep_req_i, if_busy_i, lsu_busy_i, irq_pending_i, debug_req_i, wake_i} = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_vec("reset_state", 4'b1100);
    rst_i = 1'b0;
    @(posedge clk); #1;
    prev_v = outs();
    mon_en = 1'b1;

    run_scn(0, 8, 1, 1'b0, 2);    // idle sleep, irq wake
    run_scn(7, 15, 3, 1'b0, 1);   // drain waits on lsu
    run_scn(20, 30, 1, 1'b0, 0);  // if bus stuck: timeout
    run_scn(4, 5, 2, 1'b0, 2);    // debug arrives as bus goes idle
    run_scn(6, 4, 0, 1'b0, 1);    // request withdrawn mid-drain
    run_scn(0, 9, 2, 1'b1, 0);    // request dropped while asleep is ignored
    run_scn(DT, DT + 4, 3, 1'b0, 2);
    run_scn(DT + 1, DT + 1, 1, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      run_scn($urandom_range(DT + 4, 0), $urandom_range(DT + 8, 2), $urandom_range(3, 0),
              1'($urandom_range(1, 0)), $urandom_range(2, 0));
    end

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drained leftover=%0d required=0", exp_q.size());
    end

    mon_en      = 1'b0;
    sleep_req_i = 1'b1;
    found       = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (sleeping_o) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL sleep_entry got sleeping_o=0 after 10 cycles required 1");
    end
    @(posedge clk); #3;
    rst_i = 1'b1;
    #1;
    check_vec("async_reset", 4'b1100);
    sleep_req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("post_reset", 4'b1100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
